// File: rtl/d_uncache_axi_bridge_pkg.sv
// d_uncache_axi_bridge_pkg: shared encodings and AXI constants for the uncached data bridge
package d_uncache_axi_bridge_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AWW  = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_e;
  localparam logic       RW_READ    = 1'b0;
  localparam logic       RW_WRITE   = 1'b1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [2:0] SIZE_8B    = 3'd3;
  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction
endpackage

// File: rtl/d_uncache_axi_bridge.sv
// d_uncache_axi_bridge: single-outstanding uncached load/store as one-beat AXI4 transactions
module d_uncache_axi_bridge
  import d_uncache_axi_bridge_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uc_en,
  input  logic                uc_rw,
  input  logic [ADDR_W-1:0]   uc_addr,
  input  logic [DATA_W-1:0]   uc_wr_data,
  input  logic [DATA_W/8-1:0] uc_rwen,
  output logic [DATA_W-1:0]   uc_rd_data,
  output logic                uc_data_ok,
  output logic                uc_err,
  output logic                uc_busy,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  state_e              state, nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] rwen_q;
  logic [DATA_W-1:0]   rd_q;
  logic                err_q;
  logic                aw_done, w_done;
  logic                aw_ok, w_ok;
  logic                unused_rlast;
  assign unused_rlast = rlast;
  assign aw_ok = aw_done | (awvalid & awready);
  assign w_ok  = w_done | (wvalid & wready);
  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end
  // next-state decode; AW and W retire independently before moving to B
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = uc_en ? (uc_rw == RW_WRITE ? S_AWW : S_AR) : S_IDLE;
      S_AR:    nxt = arready ? S_R : S_AR;
      S_R:     nxt = rvalid ? S_DONE : S_R;
      S_AWW:   nxt = (aw_ok && w_ok) ? S_B : S_AWW;
      S_B:     nxt = bvalid ? S_DONE : S_B;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // request capture, write-channel flags, read data and error latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rwen_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (state == S_IDLE && uc_en) begin
        addr_q  <= uc_addr;
        wdata_q <= uc_wr_data;
        rwen_q  <= uc_rwen;
      end
      aw_done <= (nxt == S_AWW) && aw_ok;
      w_done  <= (nxt == S_AWW) && w_ok;
      if (state == S_R && rvalid) begin
        rd_q  <= rdata;
        err_q <= rresp != RESP_OKAY;
      end
      if (state == S_B && bvalid) err_q <= bresp != RESP_OKAY;
    end
  end
  assign uc_rd_data = rd_q;
  assign uc_data_ok = state == S_DONE;
  assign uc_err     = (state == S_DONE) && err_q;
  assign uc_busy    = state != S_IDLE;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = axi_size(DATA_W / 8);
  assign arburst = BURST_INCR;
  assign arvalid = state == S_AR;
  assign rready  = state == S_R;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = axi_size(DATA_W / 8);
  assign awburst = BURST_INCR;
  assign awvalid = (state == S_AWW) && !aw_done;
  assign wdata   = wdata_q;
  assign wstrb   = rwen_q;
  assign wvalid  = (state == S_AWW) && !w_done;
  assign wlast   = wvalid;
  assign bready  = state == S_B;
endmodule

// File: tb/tb_d_uncache_axi_bridge.sv
// tb_d_uncache_axi_bridge: directed vector bench with a wait-programmable AXI slave
module tb_d_uncache_axi_bridge;
  logic clk = 0, reset = 0;
  logic uc_en = 0, uc_rw = 0;
  logic [31:0] uc_addr = 0, uc_wr_data = 0, uc_rd_data;
  logic [3:0] uc_rwen = 0;
  logic uc_data_ok, uc_err, uc_busy;
  logic [3:0] arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, arready, rready, rvalid, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0, bresp = 0;
  logic [3:0] wstrb;
  int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int cyc = 0, ar_n = 0, aw_n = 0, w_n = 0, ar_c = 0, aw_c = 0, w_c = 0, pay_bad = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0] exp_strb = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  d_uncache_axi_bridge dut (
    .clk(clk), .reset(reset), .uc_en(uc_en), .uc_rw(uc_rw), .uc_addr(uc_addr),
    .uc_wr_data(uc_wr_data), .uc_rwen(uc_rwen), .uc_rd_data(uc_rd_data),
    .uc_data_ok(uc_data_ok), .uc_err(uc_err), .uc_busy(uc_busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(1'b1),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  assign arready = arvalid && ar_cnt >= ar_w;
  assign rvalid  = rready && r_cnt >= r_w;
  assign awready = awvalid && aw_cnt >= aw_w;
  assign wready  = wvalid && w_cnt >= w_w;
  assign bvalid  = bready && b_cnt >= b_w;
  // slave wait counters and handshake log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (rready && !rvalid) ? r_cnt + 1 : 0;
    aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
    b_cnt  <= (bready && !bvalid) ? b_cnt + 1 : 0;
    if (arvalid && arready) begin ar_n <= ar_n + 1; ar_c <= cyc; end
    if (awvalid && awready) begin aw_n <= aw_n + 1; aw_c <= cyc; end
    if (wvalid && wready) begin w_n <= w_n + 1; w_c <= cyc; end
  end
  // AXI payload and exclusivity monitor
  always @(negedge clk) begin
    if (reset) begin
      if (arvalid && (araddr !== exp_addr || arlen !== 8'd0 || arsize !== 3'd2 || arburst !== 2'b01 || arid !== 4'h1)) pay_bad++;
      if (awvalid && (awaddr !== exp_addr || awlen !== 8'd0 || awsize !== 3'd2 || awburst !== 2'b01 || awid !== 4'h1)) pay_bad++;
      if (wvalid && (wdata !== exp_wdata || wstrb !== exp_strb || wlast !== 1'b1)) pay_bad++;
      if (arvalid && awvalid) pay_bad++;
    end
  end
  typedef struct {
    logic rw; logic [31:0] addr, wdata; logic [3:0] rwen;
    logic [31:0] rdata; logic [1:0] rresp, bresp;
    int ar_w, r_w, aw_w, w_w, b_w; bit tog;
    int e_lat; logic [31:0] e_rd; logic e_err; int e_a, e_w;
  } vec_t;
  vec_t vec [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic setup(input vec_t v);
    ar_w = v.ar_w; r_w = v.r_w; aw_w = v.aw_w; w_w = v.w_w; b_w = v.b_w;
    rdata = v.rdata; rresp = v.rresp; bresp = v.bresp;
    exp_addr = v.addr; exp_wdata = v.wdata; exp_strb = v.rwen;
    uc_en = 1; uc_rw = v.rw; uc_addr = v.addr; uc_wr_data = v.wdata; uc_rwen = v.rwen;
  endtask
  task automatic run(input vec_t v, input string tag);
    int t0, lat, okn, bb, ar0, aw0, w0, pb0;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    setup(v);
    t0 = cyc; ar0 = ar_n; aw0 = aw_n; w0 = w_n; pb0 = pay_bad;
    lat = -1; okn = 0; bb = 0; rd = 0; er = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (v.tog && arvalid) uc_addr = ~uc_addr;
      if (lat < 0 && !uc_busy) bb++;
      if (uc_data_ok) begin
        okn++;
        if (lat < 0) begin lat = k; rd = uc_rd_data; er = uc_err; end
        uc_en = 0;
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
    chk({tag, ".latency"}, lat, v.e_lat);
    chk({tag, ".rd_data"}, rd, v.e_rd);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, v.e_err});
    chk({tag, ".ok_pulses"}, okn, 1);
    chk({tag, ".payload"}, pay_bad - pb0, 0);
    chk({tag, ".busy"}, bb, 0);
    if (v.rw) begin
      chk({tag, ".aw_count"}, aw_n - aw0, 1);
      chk({tag, ".w_count"}, w_n - w0, 1);
      chk({tag, ".ar_count"}, ar_n - ar0, 0);
      chk({tag, ".aw_cycle"}, aw_c - t0, v.e_a);
      chk({tag, ".w_cycle"}, w_c - t0, v.e_w);
    end else begin
      chk({tag, ".ar_count"}, ar_n - ar0, 1);
      chk({tag, ".aw_w_count"}, (aw_n - aw0) + (w_n - w0), 0);
      chk({tag, ".ar_cycle"}, ar_c - t0, v.e_a);
    end
  endtask
  initial begin
    int t0, t_ok, t_ar, okn, aw0, w0, ar0;
    vec_t b;
    vec[0] = '{0, 32'h1000_0004, 0, 4'h0, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 0, 1, 0};
    vec[1] = '{1, 32'hBFD0_0010, 32'h1234_5678, 4'b0011, 0, 2'b00, 2'b00, 0, 0, 3, 0, 0, 0, 6, 32'hDEADBEEF, 0, 4, 1};
    vec[2] = '{0, 32'h1000_0008, 0, 4'h0, 32'h0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 3, 32'h0, 1, 1, 0};
    vec[3] = '{0, 32'h1000_000C, 0, 4'h0, 32'hCAFEF00D, 2'b00, 2'b00, 0, 2, 0, 0, 0, 0, 5, 32'hCAFEF00D, 0, 1, 0};
    vec[4] = '{1, 32'hBFD0_0020, 32'h8765_4321, 4'b1100, 0, 2'b00, 2'b11, 0, 0, 0, 2, 1, 0, 6, 32'hCAFEF00D, 1, 1, 3};
    vec[5] = '{0, 32'h1FC0_0100, 0, 4'h0, 32'h0000_1111, 2'b00, 2'b00, 10, 0, 0, 0, 0, 1, 13, 32'h0000_1111, 0, 11, 0};
    vec[6] = '{1, 32'hBFD0_0030, 32'hA0B0_C0D0, 4'b1111, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 3, 32'h0000_1111, 0, 1, 1};
    vec[7] = '{0, 32'h3000_0000, 0, 4'h0, 32'hA5A5_5A5A, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 3, 32'hA5A5_5A5A, 0, 1, 0};
    repeat (3) @(negedge clk);
    chk("rst.valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst.status", {29'd0, uc_data_ok, uc_err, uc_busy}, 0);
    chk("rst.rd_data", uc_rd_data, 0);
    reset = 1;
    for (int i = 0; i < 7; i++) run(vec[i], $sformatf("v%0d", i));
    b = vec[6];
    b.addr = 32'h2000_0000; b.wdata = 32'h0000_55AA; b.rwen = 4'hF; b.rdata = 32'h0BAD_F00D;
    @(negedge clk);
    setup(b);
    t0 = cyc; t_ok = -1; t_ar = -1; okn = 0; aw0 = aw_n; w0 = w_n; ar0 = ar_n;
    for (int k = 1; k <= 30 && okn < 2; k++) begin
      @(negedge clk);
      if (arvalid && t_ar < 0) t_ar = k;
      if (uc_data_ok) begin
        okn++;
        if (okn == 1) begin
          t_ok = k; uc_rw = 0; uc_addr = 32'h2000_0004; exp_addr = 32'h2000_0004;
        end else uc_en = 0;
      end
    end
    uc_en = 0;
    repeat (2) @(negedge clk);
    chk("b2b.ok_pulses", okn, 2);
    chk("b2b.ar_gap", t_ar - t_ok, 2);
    chk("b2b.aw_count", aw_n - aw0, 1);
    chk("b2b.w_count", w_n - w0, 1);
    chk("b2b.ar_count", ar_n - ar0, 1);
    chk("b2b.rd_data", uc_rd_data, 32'h0BAD_F00D);
    b.addr = 32'h4000_0000; b.b_w = 20;
    @(negedge clk);
    setup(b);
    for (int k = 0; k < 10 && !bready; k++) @(negedge clk);
    chk("mid.in_b", {31'd0, bready}, 1);
    reset = 0; uc_en = 0;
    @(negedge clk);
    chk("mid.valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("mid.busy", {31'd0, uc_busy}, 0);
    chk("mid.rd_data", uc_rd_data, 0);
    reset = 1;
    run(vec[7], "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/d_uncache_axi_bridge.md
# d_uncache_axi_bridge

Responder for the data-side uncached request interface. Accepts one uncached load or store at a time from the d-cache arbitrator and performs it as a single-beat AXI4 transaction. Returns read data and a one-cycle `data_ok` completion pulse. Sits between the arbitrator's `cpu_mem_uncache_*` port and the AXI interconnect, in parallel with the D-cache refill path.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; one AXI beat.
- `AXI_ID`, 4'h1: constant ID driven on `arid` and `awid`.

Ports:
- `clk`  in  1  sole clock. One clock; reset is synchronous and active-low.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `uc_en`  in  1  request valid. The requester holds it, with all request fields, until `uc_data_ok`.
- `uc_rw`  in  1  1 = write, 0 = read.
- `uc_addr`  in  ADDR_W  byte address.
- `uc_wr_data`  in  DATA_W  store data.
- `uc_rwen`  in  DATA_W/8  byte enables for a write.
- `uc_rd_data`  out  DATA_W  load data.
- `uc_data_ok`  out  1  one-cycle completion pulse.
- `uc_err`  out  1  high together with `uc_data_ok` when the AXI response is not OKAY.
- `uc_busy`  out  1  state ≠ IDLE.
- AXI4 AR channel: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arvalid` out; `arready` in.
- AXI4 R channel: `rdata`, `rresp`, `rlast`, `rvalid` in; `rready` out.
- AXI4 AW channel: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid` out; `awready` in.
- AXI4 W channel: `wdata`, `wstrb`, `wlast`, `wvalid` out; `wready` in.
- AXI4 B channel: `bresp`, `bvalid` in; `bready` out.

## Operation
- Fixed fields:
  - `arlen`/`awlen` = 0.
  - `arsize`/`awsize` = log2(DATA_W/8).
  - `arburst`/`awburst` = INCR (2'b01).
  - `wlast` = `wvalid`.
- Request capture: in IDLE, `uc_en` = 1 registers addr, rw, wr_data and rwen into request registers. Those registers drive AXI for the whole transaction; later input changes are ignored.
- States: IDLE, AR, R, AWW, B, DONE.
- Transitions:
  - IDLE: `uc_en` & !`uc_rw` → AR; `uc_en` & `uc_rw` → AWW; otherwise stay.
  - AR: `arvalid` = 1; on `arready` → R.
  - R: `rready` = 1; on `rvalid` → DONE, latching `rdata` into `uc_rd_data` and `rresp` ≠ 0 into the error register.
  - AWW: `awvalid` and `wvalid` start together and each deasserts after its own handshake, tracked by `aw_done`/`w_done` flags. When both are done (the same cycle is allowed) → B.
  - B: `bready` = 1; on `bvalid` → DONE, latching `bresp` ≠ 0 into the error register.
  - DONE: `uc_data_ok` = 1 and `uc_err` = error register for exactly one cycle → IDLE.
- `uc_rd_data` holds its value until the next read completes. Writes do not change it.
- A new request is sampled only in IDLE, so a back-to-back request still held on `uc_en` after DONE is accepted one cycle after the `uc_data_ok` pulse.
- No outstanding transactions beyond one. AR and AW are never both valid.
- Error responses (SLVERR/DECERR) complete normally with `uc_err` = 1. No retry.

## Timing
- Reset values, all synchronous:
  - State = IDLE.
  - All `*valid` and `*ready` outputs = 0.
  - `uc_data_ok`, `uc_err`, `uc_busy` = 0.
  - `uc_rd_data` = 0.
  - `aw_done` = `w_done` = 0.
- Minimum read latency (`arready` and `rvalid` immediate): `uc_en` at cycle 0 → `arvalid` at cycle 1 → R at cycle 2 → `uc_data_ok` at cycle 3.
- Minimum write latency: `uc_en` at cycle 0 → AW/W at cycle 1 → B at cycle 2 → `uc_data_ok` at cycle 3.
- All outputs are registered or decoded from state only. There is no combinational path from AXI inputs to AXI outputs.
- AXI rules: once asserted, a valid stays high with a stable payload until its handshake.
- Reset mid-transaction: returns to IDLE immediately and drops all valids. This is legal only because system reset also resets the interconnect.

## Structure
- Shared package holds:
  - State encoding (3-bit).
  - RW encoding (READ = 0, WRITE = 1).
  - AXI constants: BURST_INCR, RESP_OKAY, size codes.
- Single FSM module with no sub-module. Write-channel tracking stays inline as two flag registers.

## Test plan
- Read, AXI slave zero-wait with `rdata` = 32'hDEADBEEF → `uc_data_ok` at cycle 3, `uc_rd_data` = 32'hDEADBEEF, `araddr` = `uc_addr`, `arlen` = 0.
- Write with addr 32'hBFD0_0010, data 32'h1234_5678, `uc_rwen` = 4'b0011; `awready` after 3 cycles, `wready` immediate → W handshakes first, AW at cycle 4, then B; `wstrb` = 4'b0011; exactly one `uc_data_ok`.
- Store then load held back-to-back on `uc_en` → the load's `arvalid` rises exactly 2 cycles after the store's `uc_data_ok`; there is no duplicate write.
- Read with `rresp` = 2'b10 and `rdata` = 32'h0 → `uc_data_ok` and `uc_err` both 1 in the same cycle; the next OKAY read gives `uc_err` = 0.
- `arready` held 0 for 10 cycles while `uc_addr` toggles → `araddr` stays at the captured address, `arvalid` stays high, `uc_busy` = 1.
- `reset` = 0 while in B → next cycle all valids/readies = 0 and `uc_busy` = 0; a new read after release completes normally.
